// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: RV32I load/store unit in front of a single-port SRAM.
// The SRAM captures its inputs at posedge and updates dout at negedge. Load
// data is therefore valid in the cycle after acceptance.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses with rsp_err. When it is not defined, the low offset
// bits are cleared and the aligned access is performed.
module lsu_sram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [3:0]            sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RSP     = 2'd2;

    logic [1:0] state;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic       err_q;

    logic       legal;
    logic       fault;
    logic       accept;
    logic       access;
    logic [1:0] size;
    logic [1:0] off;
    logic       unused_addr;

    // Select the byte or halfword lane and extend it according to funct3.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Address bits above the SRAM word range are intentionally ignored.
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2]};

    // Decode legality, access size and the effective byte offset.
    always_comb begin
        size  = req_funct3[1:0];
        legal = req_we ? (!req_funct3[2] && (size != 2'b11))
                       : ((size != 2'b11) && (req_funct3[2:1] != 2'b11));
        case (size)
            2'b00:   off = req_addr[1:0];
            2'b01:   off = {req_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size == 2'b01) && req_addr[0]) ||
                        ((size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign fault = !legal || misaligned;
`else
    assign fault = !legal;
`endif

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign access    = accept && !fault;

    // The SRAM strobes are driven combinationally only in the accept cycle.
    always_comb begin
        sram_csb   = !access;
        sram_web   = !(access && req_we);
        sram_addr  = req_addr[ADDR_WIDTH+1:2];
        sram_wmask = 4'b0000;
        case (size)
            2'b00:   sram_din = {4{req_wdata[7:0]}};
            2'b01:   sram_din = {2{req_wdata[15:0]}};
            default: sram_din = req_wdata;
        endcase
        if (access && req_we) begin
            case (size)
                2'b00:   sram_wmask = 4'b0001 << off;
                2'b01:   sram_wmask = 4'b0011 << off;
                default: sram_wmask = 4'b1111;
            endcase
        end
    end

    // Response outputs follow the state; load data comes straight from the SRAM.
    always_comb begin
        rsp_valid = (state != IDLE);
        rsp_err   = (state == RSP) && err_q;
        rsp_rdata = (state == RD_WAIT) ? load_extract(f3_q, off_q, sram_dout) : '0;
    end

    // Control FSM: IDLE -> RD_WAIT for loads, IDLE -> RSP for stores/faults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_q <= fault;
                        state <= (fault || req_we) ? RSP : RD_WAIT;
                    end
                end
                RD_WAIT, RSP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember how to extract the load result once the SRAM data arrives.
    always_ff @(posedge clk) begin
        if (access && !req_we) begin
            f3_q  <= req_funct3;
            off_q <= off;
        end
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// tb_lsu_sram_ctrl: directed bench for lsu_sram_ctrl with a byte-level
// reference model, a posedge-capture / negedge-update SRAM model, and a
// per-cycle compare process.
module tb_lsu_sram_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sram_csb;
    logic        sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int cmp_cnt = 0;
    int err_cnt = 0;

    lsu_sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:255];
    logic [7:0]  rd_a;
    logic        rd_go;

    always @(posedge clk) begin
        rd_go <= 1'b0;
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wmask[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
            end else begin
                rd_a  <= sram_addr;
                rd_go <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rd_go) sram_dout <= mem[rd_a];
    end

    // ---------------- reference model ----------------
    logic [7:0]  refmem [0:1023];
    bit          model_on = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_rdata = '0;

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit fault_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int n;
        n = size_of(f3);
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || (TRAP && ((int'(a[1:0]) % n) != 0));
    endfunction

    function automatic int low_of(input logic [31:0] a, input int n);
        int lo;
        lo = int'(a[1:0]);
        return lo - (lo % n);
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n, base;
        n = size_of(f3);
        base = int'(a[9:2]) * 4 + low_of(a, n);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refmem[base + i];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare, then advance the model by one clock.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (model_on) begin
                bit          acc, flt, acs;
                int          n, lo, base;
                logic [3:0]  em;
                logic [31:0] ed;
                acc = !m_busy && req_valid && !rst;
                flt = fault_of(req_we, req_funct3, req_addr);
                acs = acc && !flt;
                n   = size_of(req_funct3);
                lo  = low_of(req_addr, n);
                chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy && !rst});
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_busy});
                chk("sram_csb", {31'd0, sram_csb}, {31'd0, !acs});
                chk("sram_web", {31'd0, sram_web}, {31'd0, !(acs && req_we)});
                em = '0;
                if (acs && req_we) for (int i = 0; i < n; i++) em[lo + i] = 1'b1;
                chk("sram_wmask", {28'd0, sram_wmask}, {28'd0, em});
                if (acs) chk("sram_addr", {24'd0, sram_addr}, {24'd0, req_addr[9:2]});
                if (acs && req_we) begin
                    for (int i = 0; i < 4; i++) ed[8*i +: 8] = req_wdata[8*(i % n) +: 8];
                    chk("sram_din", sram_din, ed);
                end
                if (m_busy) begin
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
                end
                if (rst) begin
                    m_busy = 1'b0;
                end else if (m_busy) begin
                    if (rsp_ready) m_busy = 1'b0;
                end else if (acc) begin
                    m_busy  = 1'b1;
                    m_err   = flt;
                    m_rdata = '0;
                    if (!flt) begin
                        base = int'(req_addr[9:2]) * 4 + lo;
                        if (req_we) for (int i = 0; i < n; i++) refmem[base + i] = req_wdata[8*i +: 8];
                        else        m_rdata = load_val(req_funct3, req_addr);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        a_csb;
    logic [3:0]  a_mask;
    logic [7:0]  a_addr;
    logic [31:0] a_din;
    logic [31:0] r_data;
    logic        r_err;

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk); #2;
        a_csb = sram_csb; a_mask = sram_wmask; a_addr = sram_addr; a_din = sram_din;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = (hold == 0);
        @(negedge clk); #2;
        r_data = rsp_rdata; r_err = rsp_err;
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                @(posedge clk); #1;
                @(negedge clk); #2;
                chk("hold_rdata", rsp_rdata, r_data);
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk); #2;
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk); #2;
        chk("back_to_idle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cmp=%0d", cmp_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 1024; i++) refmem[i] = '0;
        sram_dout = '0; rd_go = 1'b0; rd_a = '0;
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h8; req_wdata = '0;

        // A request held during reset must not be accepted.
        @(posedge clk); #1;
        model_on = 1'b1;
        @(negedge clk); #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_csb", {31'd0, sram_csb}, 32'd1);
        chk("rst_wmask", {28'd0, sram_wmask}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;

        txn(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 0);
        chk("sw_addr", {24'd0, a_addr}, 32'd2);
        chk("sw_mask", {28'd0, a_mask}, 32'hF);
        chk("sw_err", {31'd0, r_err}, 32'd0);
        txn(1'b0, 3'b010, 32'h8, 32'h0, 0);
        chk("lw_rdata", r_data, 32'hDEADBEEF);

        txn(1'b1, 3'b000, 32'h9, 32'h80, 0);
        chk("sb_mask", {28'd0, a_mask}, 32'h2);
        txn(1'b0, 3'b000, 32'h9, 32'h0, 0);
        chk("lb_rdata", r_data, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'h9, 32'h0, 0);
        chk("lbu_rdata", r_data, 32'h00000080);

        txn(1'b1, 3'b001, 32'hA, 32'h8001, 0);
        chk("sh_mask", {28'd0, a_mask}, 32'hC);
        chk("sh_din_hi", {16'd0, a_din[31:16]}, 32'h8001);
        txn(1'b0, 3'b001, 32'hA, 32'h0, 0);
        chk("lh_rdata", r_data, 32'hFFFF8001);
        txn(1'b0, 3'b101, 32'hA, 32'h0, 0);
        chk("lhu_rdata", r_data, 32'h00008001);
        txn(1'b0, 3'b010, 32'h8, 32'h0, 0);
        chk("lw_merged", r_data, 32'h800180EF);

        // Misaligned word load.
        txn(1'b1, 3'b010, 32'h4, 32'h12345678, 0);
        txn(1'b0, 3'b010, 32'h6, 32'h0, 0);
        if (TRAP) begin
            chk("lw6_csb", {31'd0, a_csb}, 32'd1);
            chk("lw6_err", {31'd0, r_err}, 32'd1);
            chk("lw6_rdata", r_data, 32'd0);
        end else begin
            chk("lw6_csb", {31'd0, a_csb}, 32'd0);
            chk("lw6_err", {31'd0, r_err}, 32'd0);
            chk("lw6_rdata", r_data, 32'h12345678);
        end

        // Misaligned halfword load (trap or aligned-down access).
        txn(1'b0, 3'b101, 32'h7, 32'h0, 0);
        chk("lhu7_rdata", r_data, TRAP ? 32'd0 : 32'h00001234);

        // Illegal funct3 on load and store.
        txn(1'b0, 3'b011, 32'h8, 32'h0, 0);
        chk("ill_ld_csb", {31'd0, a_csb}, 32'd1);
        chk("ill_ld_err", {31'd0, r_err}, 32'd1);
        txn(1'b1, 3'b100, 32'h8, 32'hFFFFFFFF, 0);
        chk("ill_st_csb", {31'd0, a_csb}, 32'd1);
        chk("ill_st_err", {31'd0, r_err}, 32'd1);
        txn(1'b0, 3'b110, 32'h8, 32'h0, 0);
        chk("ill_ld6_err", {31'd0, r_err}, 32'd1);

        // Upper address bits alias onto the same SRAM word.
        txn(1'b0, 3'b010, 32'h408, 32'h0, 0);
        chk("alias_addr", {24'd0, a_addr}, 32'd2);
        chk("alias_rdata", r_data, 32'h800180EF);

        // Back-pressure: response held for 3 cycles.
        txn(1'b0, 3'b010, 32'h4, 32'h0, 3);
        chk("hold_lw_rdata", r_data, 32'h12345678);

        // Reset while a load response is pending.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0; rst = 1'b1;
        @(negedge clk); #2;
        chk("rdwait_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #2;
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b1;

        txn(1'b0, 3'b000, 32'hB, 32'h0, 0);
        chk("lb_after_rst", r_data, 32'hFFFFFF80);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_sram_ctrl.md
LSU_SRAM_CTRL -- requirements
Module: lsu_sram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width; only 32 is supported.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; it also drives the SRAM port-0 clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port req_valid, input, 1 bit: the core presents a load/store request.
REQ-007 Port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-008 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 Port req_funct3, input, 3 bits: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-010 Port req_addr, input, 32 bits: byte address.
REQ-011 Port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 Port rsp_valid, output, 1 bit: a response is present.
REQ-013 Port rsp_ready, input, 1 bit: the core consumes the response.
REQ-014 Port rsp_rdata, output, 32 bits: the extended load result, or 0 for stores and errors.
REQ-015 Port rsp_err, output, 1 bit: illegal funct3, or misaligned access.
REQ-016 Port sram_csb, output, 1 bit: active-low chip select.
REQ-017 Port sram_web, output, 1 bit: active-low write enable.
REQ-018 Port sram_wmask, output, 4 bits: byte write mask.
REQ-019 Port sram_addr, output, ADDR_WIDTH bits: word address.
REQ-020 Port sram_din, output, 32 bits: lane-shifted write data.
REQ-021 Port sram_dout, input, 32 bits: read data from SRAM port 0.

Function
REQ-022 The FSM SHALL have states IDLE, RD_WAIT and RSP; req_ready SHALL be 1 only in IDLE.
REQ-023 A request SHALL be accepted on req_valid&&req_ready; sram_addr SHALL be req_addr[ADDR_WIDTH+1:2], and address bits above that SHALL be ignored (aliasing).
REQ-024 On load acceptance, the block SHALL drive sram_csb=0 and sram_web=1 combinationally in the same cycle, latch funct3 and addr[1:0], and go to RD_WAIT.
REQ-025 In RD_WAIT, rsp_valid SHALL be 1 and rsp_rdata SHALL be formed combinationally from sram_dout; the data is valid one cycle after acceptance because the SRAM captures its inputs at posedge and updates dout at negedge.
REQ-026 Load extraction: LB/LBU SHALL select byte addr[1:0]; LH/LHU SHALL select the halfword at addr[1]; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word through.
REQ-027 On store acceptance, the block SHALL drive sram_csb=0 and sram_web=0 in the same cycle.
REQ-028 Store mask and data: SB SHALL drive wmask=1<<addr[1:0] and replicate the byte on all lanes; SH SHALL drive wmask=4'b0011<<addr[1:0] and replicate the halfword; SW SHALL drive wmask=4'b1111.
REQ-029 After a store is accepted, the block SHALL go to RSP with rsp_rdata=0 and rsp_err=0.
REQ-030 In RD_WAIT or RSP, the block SHALL hold rsp_valid until rsp_ready; on rsp_ready it SHALL return to IDLE, so the next request can be accepted no earlier than the following cycle.
REQ-031 Outside an accept cycle, sram_csb SHALL be 1, sram_web SHALL be 1, and sram_wmask SHALL be 0; no SRAM access SHALL occur while a response is pending, so sram_dout stays stable during RD_WAIT.
REQ-032 Illegal funct3 (011, 11x, or a store with funct3[2]=1) SHALL cause no SRAM access, a transition to RSP, rsp_err=1 and rsp_rdata=0.

Reset
REQ-033 rst SHALL force IDLE with rsp_valid=0, rsp_err=0, rsp_rdata=0, sram_csb=1, sram_web=1 and sram_wmask=0.
REQ-034 rst asserted in RD_WAIT or RSP SHALL drop the pending response without a handshake.
REQ-035 A request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-036 With LSU_MISALIGN_TRAP_EN defined, an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, SHALL cause no SRAM access and SHALL respond via RSP with rsp_err=1.
REQ-037 Without LSU_MISALIGN_TRAP_EN, the block SHALL clear the low offset bits (halfword: addr[0]; word: addr[1:0]) and perform the aligned access with rsp_err=0.

Verification
REQ-038 After reset, SW addr=0x8 wdata=0xDEADBEEF, then LW addr=0x8 -> during the SW accept cycle sram_addr=2 and sram_wmask=1111; the LW returns rsp_rdata=0xDEADBEEF one cycle after acceptance.
REQ-039 SB addr=0x9 wdata=0x80, then LB addr=0x9 and LBU addr=0x9 -> wmask=0010; LB returns 0xFFFFFF80 and LBU returns 0x00000080.
REQ-040 SH addr=0xA wdata=0x8001, then LH addr=0xA -> wmask=1100, sram_din[31:16]=0x8001, and rsp_rdata=0xFFFF8001.
REQ-041 LW addr=0x6 -> with the macro: no csb assertion, rsp_err=1, rsp_rdata=0; without the macro: the word at addr 0x4 is returned with rsp_err=0.
REQ-042 Hold rsp_ready=0 for 3 cycles after an LW, and assert rst during RD_WAIT in a second run -> in the first run rdata stays stable and req_ready stays 0; in the second run the next cycle is IDLE with rsp_valid=0.
